// File: rtl/uart_tx.sv
// uart_tx: 8N1 / 8E1 / 8O1 serial transmitter.
// Frame = start(0), 8 data bits LSB first, optional parity, stop(1).
// Each bit lasts 'prescale' clocks; a latched prescale of 0 behaves as 1.
// Outputs are registered and derived from the next state, so they change
// on the same edge as the state register.
module uart_tx (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       data_valid,
  input  logic [5:0] prescale,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       TX_OUT,
  output logic       busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] pre_q, pre_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic       tx_d, busy_d, done_d;
  logic [5:0] last_cnt;
  logic       bit_end;
  logic       parity_bit;

  // Frame sequencing, counters and next-cycle output values.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pre_d     = pre_q;
    idx_d     = idx_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    // prescale 0 folds onto 1: the last count is 0 either way
    last_cnt   = (pre_q == 6'd0) ? 6'd0 : pre_q - 6'd1;
    bit_end    = (cnt_q == last_cnt);
    parity_bit = par_typ_q ? ~^data_q : ^data_q;

    case (state_q)
      IDLE: begin
        if (data_valid) begin
          data_d    = P_DATA;
          pre_d     = prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          cnt_d     = 6'd0;
          state_d   = START;
        end
      end
      START: begin
        cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        if (bit_end) begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
      end
      DATA: begin
        cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      PARITY: begin
        cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        cnt_d = bit_end ? 6'd0 : cnt_q + 6'd1;
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // line level for the state about to be entered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[idx_d];
      PARITY:  tx_d = parity_bit;
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  // State, frame registers and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      pre_q     <= 6'd0;
      idx_q     <= 3'd0;
      data_q    <= 8'd0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      TX_OUT    <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      TX_OUT    <= tx_d;
      busy      <= busy_d;
      tx_done   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table of frames plus hand-written corner sequences.
// Expected frames go to a queue when driven; a line monitor captures TX_OUT
// while busy, decodes the frame like a receiver would and compares.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic [5:0] prescale;
  logic       PAR_EN, PAR_TYP;
  logic       TX_OUT, busy, tx_done;

  uart_tx dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .data_valid(data_valid),
    .prescale(prescale), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .TX_OUT(TX_OUT), .busy(busy), .tx_done(tx_done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    logic [5:0] pre;
    int         ppb;      // cycles per bit actually expected
    logic       par_en;
    logic       par_typ;
    logic       exp_par;
    int         exp_len;
  } exp_t;

  exp_t exp_q[$];
  logic wave[$];
  int   errors = 0, checks = 0;
  int   done_pulses = 0, frames_done = 0;
  int   idle_cnt = 0, last_gap = 0;
  bit   prev_busy = 0, aborting = 0;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic [5:0] p, input logic pe,
                              input logic pt, input logic ep, input int len);
    exp_t e;
    e.data = d; e.pre = p; e.ppb = (p == 6'd0) ? 1 : int'(p);
    e.par_en = pe; e.par_typ = pt; e.exp_par = ep; e.exp_len = len;
    return e;
  endfunction

  task automatic frame_end();
    exp_t e;
    int   nbits, idx, sidx;
    logic ebit, rxb;
    bit   ok;
    logic [7:0] rx;
    if (exp_q.size() == 0) begin
      chk(0, "unexpected_frame", wave.size(), 0);
    end else begin
      e = exp_q.pop_front();
      frames_done++;
      chk(tx_done === 1'b1, "tx_done_at_end", int'(tx_done), 1);
      chk(wave.size() == e.exp_len, "frame_len", wave.size(), e.exp_len);
      nbits = e.par_en ? 11 : 10;
      for (int k = 0; k < nbits; k++) begin
        if (k == 0)                     ebit = 1'b0;
        else if (k <= 8)                ebit = e.data[k-1];
        else if (k == 9 && e.par_en)    ebit = e.exp_par;
        else                            ebit = 1'b1;
        ok = 1;
        for (int j = 0; j < e.ppb; j++) begin
          idx = k * e.ppb + j;
          if (idx >= wave.size() || wave[idx] !== ebit) ok = 0;
        end
        chk(ok, $sformatf("bit%0d_data%02h", k, e.data), int'(ok), 1);
      end
      // receiver-style decode: sample mid-bit
      rx = 8'h00;
      for (int b = 0; b < 8; b++) begin
        sidx = (b + 1) * e.ppb + e.ppb / 2;
        rxb = (sidx < wave.size()) ? wave[sidx] : 1'bx;
        rx[b] = rxb;
      end
      chk(rx === e.data, "rx_data", int'(rx), int'(e.data));
    end
    wave.delete();
  endtask

  // Line monitor: capture TX_OUT while busy, decode on busy fall.
  always @(negedge CLK) begin
    if (RST) begin
      if (busy === 1'b1) aborting = 1;
      wave.delete();
      prev_busy = (busy === 1'b1);
    end else begin
      if (tx_done === 1'b1) done_pulses++;
      if (busy === 1'b1) begin
        if (!prev_busy) begin
          last_gap = idle_cnt;
          idle_cnt = 0;
        end
        wave.push_back(TX_OUT);
      end else begin
        if (prev_busy) begin
          if (aborting) begin
            aborting = 0;
            wave.delete();
          end else frame_end();
        end
        if (TX_OUT !== 1'b1) chk(0, "idle_line_high", int'(TX_OUT), 1);
        idle_cnt++;
      end
      prev_busy = (busy === 1'b1);
    end
  end

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (busy === 1'b0) done = 1;
      else begin @(posedge CLK); #1; end
    end
    if (!done) chk(0, "wait_idle_timeout", 0, 1);
  endtask

  task automatic send(input exp_t e, input bit push);
    wait_idle();
    P_DATA = e.data; prescale = e.pre; PAR_EN = e.par_en; PAR_TYP = e.par_typ;
    data_valid = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge CLK); #1;
    data_valid = 1'b0;
  endtask

  exp_t vec[5];
  int   d0;
  bit   seen;

  initial begin
    RST = 1'b1; P_DATA = 8'h00; data_valid = 1'b0; prescale = 6'd8;
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk(TX_OUT === 1'b1, "reset_tx_out", int'(TX_OUT), 1);
    chk(busy === 1'b0, "reset_busy", int'(busy), 0);
    chk(tx_done === 1'b0, "reset_tx_done", int'(tx_done), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    vec[0] = mk(8'hAB, 6'd8,  1'b0, 1'b0, 1'b0, 80);
    vec[1] = mk(8'hCD, 6'd16, 1'b1, 1'b0, 1'b1, 176);
    vec[2] = mk(8'hCD, 6'd16, 1'b1, 1'b1, 1'b0, 176);
    vec[3] = mk(8'hEF, 6'd32, 1'b1, 1'b1, 1'b0, 352);
    vec[4] = mk(8'h5A, 6'd0,  1'b0, 1'b0, 1'b0, 10);

    for (int i = 0; i < 5; i++) begin
      d0 = done_pulses;
      send(vec[i], 1);
      chk(busy === 1'b1 && TX_OUT === 1'b0, $sformatf("accept_vec%0d", i),
          int'({busy, TX_OUT}), 2);
      wait_idle();
      repeat (2) @(posedge CLK); #1;
      chk(done_pulses - d0 == 1, $sformatf("done_pulses_vec%0d", i), done_pulses - d0, 1);
    end

    // requests and input changes mid-frame are ignored
    send(mk(8'hAB, 6'd8, 1'b0, 1'b0, 1'b0, 80), 1);
    repeat (30) @(posedge CLK); #1;
    P_DATA = 8'h55; prescale = 6'd32; PAR_EN = 1'b1; data_valid = 1'b1;
    @(posedge CLK); #1;
    data_valid = 1'b0;
    repeat (5) @(posedge CLK); #1;
    prescale = 6'd8; PAR_EN = 1'b0;
    wait_idle();
    repeat (2) @(posedge CLK); #1;

    // back-to-back with data_valid held high
    d0 = done_pulses;
    P_DATA = 8'h0F; prescale = 6'd8; PAR_EN = 1'b0; data_valid = 1'b1;
    exp_q.push_back(mk(8'h0F, 6'd8, 1'b0, 1'b0, 1'b0, 80));
    @(posedge CLK); #1;
    P_DATA = 8'hF0;
    exp_q.push_back(mk(8'hF0, 6'd8, 1'b0, 1'b0, 1'b0, 80));
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (tx_done === 1'b1) seen = 1;
      else begin @(posedge CLK); #1; end
    end
    chk(seen, "b2b_first_done", int'(seen), 1);
    chk(busy === 1'b0, "b2b_gap_busy_low", int'(busy), 0);
    @(posedge CLK); #1;
    data_valid = 1'b0;
    chk(busy === 1'b1 && TX_OUT === 1'b0, "b2b_second_accept", int'({busy, TX_OUT}), 2);
    wait_idle();
    repeat (2) @(posedge CLK); #1;
    chk(last_gap == 1, "b2b_idle_gap", last_gap, 1);
    chk(done_pulses - d0 == 2, "b2b_done_pulses", done_pulses - d0, 2);

    // reset during data bit 3 (frame bit 4 spans cycles N+33..N+40)
    send(mk(8'hAB, 6'd8, 1'b0, 1'b0, 1'b0, 80), 0);
    repeat (34) @(posedge CLK); #1;
    chk(busy === 1'b1, "pre_reset_busy", int'(busy), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk(TX_OUT === 1'b1, "midreset_tx_out", int'(TX_OUT), 1);
    chk(busy === 1'b0, "midreset_busy", int'(busy), 0);
    chk(tx_done === 1'b0, "midreset_tx_done", int'(tx_done), 0);
    repeat (10) @(posedge CLK); #1;
    chk(busy === 1'b0, "no_resume", int'(busy), 0);
    send(mk(8'hAB, 6'd8, 1'b0, 1'b0, 1'b0, 80), 1);
    wait_idle();
    repeat (3) @(posedge CLK); #1;

    chk(exp_q.size() == 0, "frames_outstanding", exp_q.size(), 0);
    chk(done_pulses == frames_done, "total_done_pulses", done_pulses, frames_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1, required 0");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the existing UART receiver. It accepts a parallel byte with a one-cycle valid strobe and serialises it as start bit, 8 data bits LSB first, optional parity bit, and stop bit. Each bit is held for `prescale` system-clock cycles, so one clock and one `prescale` setting drive both ends of the link. It sits between the system-side byte producer and the serial line feeding `UART_RX`.

## Interface
- No parameters. Data width is fixed at 8; the counter width follows the 6-bit `prescale`.
- CLK  input  1  system clock; all logic on rising edge
- RST  input  1  reset, synchronous and active-high
- P_DATA  input  8  byte to transmit; sampled only on acceptance
- data_valid  input  1  request strobe; accepted only when `busy`=0
- prescale  input  6  system clocks per serial bit (8, 16, 32 in use); sampled on acceptance
- PAR_EN  input  1  1 = insert parity bit; sampled on acceptance
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled on acceptance
- TX_OUT  output  1  serial line; idles high; registered
- busy  output  1  high while a frame is in progress; registered
- tx_done  output  1  one-cycle pulse after the stop bit completes; registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If data_valid=1, latch P_DATA, PAR_EN, PAR_TYP, and prescale into internal registers, then go to START.
- Effective prescale: a latched prescale of 0 is treated as 1.
- START: TX_OUT=0 for prescale cycles, then go to DATA.
- DATA:
  - TX_OUT = data[bit_idx], starting at bit_idx=0.
  - Each bit is held for prescale cycles.
  - After bit 7, go to PARITY if the latched PAR_EN=1, otherwise go to STOP.
- PARITY:
  - TX_OUT = ^data when PAR_TYP=0, or ~^data when PAR_TYP=1.
  - Held for prescale cycles, then go to STOP.
- STOP:
  - TX_OUT=1 for prescale cycles, then go to IDLE.
  - tx_done=1 in the first IDLE cycle.
- Counters:
  - The bit-cycle counter runs 0..prescale-1 and wraps to 0 on each bit boundary.
  - bit_idx is 3 bits, reset to 0 on entry to DATA.
- Inputs are ignored while busy=1:
  - data_valid has no effect and raises no error.
  - Changes to P_DATA, prescale, PAR_EN, or PAR_TYP do not affect the frame in flight.
- Reset (RST=1 at a rising edge), including mid-frame:
  - Next cycle: state=IDLE, TX_OUT=1, busy=0, tx_done=0, counters=0.
  - The partial frame is abandoned and not resumed.

## Timing
- Acceptance: data_valid=1 at edge N while in IDLE gives TX_OUT=0 and busy=1 from cycle N+1.
- Frame length is 10×prescale cycles without parity and 11×prescale cycles with parity.
  - busy is high for exactly that many cycles.
- Bit k of the frame (start = bit 0) occupies cycles N+1+k·prescale through N+(k+1)·prescale.
- tx_done is high for exactly one cycle, the cycle busy first returns to 0.
  - data_valid in that same cycle is accepted, so back-to-back frames are separated by exactly one idle-high cycle.
- Output state after reset: TX_OUT=1, busy=0, tx_done=0.
- data_valid held high continuously starts a new frame after each one-cycle idle gap.

## Test plan
- Basic frame, no parity:
  - Stimulus: prescale=8, PAR_EN=0, P_DATA=8'hAB.
  - Required: TX_OUT sequence 0,1,1,0,1,0,1,0,1,1 with each bit held 8 cycles; busy high 80 cycles; one tx_done pulse.
- Even parity:
  - Stimulus: prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=8'hCD.
  - Required: parity bit = 1; frame of 176 cycles.
- Odd parity:
  - Stimulus: prescale=16, PAR_EN=1, PAR_TYP=1, P_DATA=8'hCD.
  - Required: parity bit = 0.
  - Same check at prescale=32 with P_DATA=8'hEF: parity bit = 0, frame of 352 cycles.
- Inputs while busy:
  - Stimulus: pulse data_valid with P_DATA=8'h55 and change prescale to 32 midway through a prescale=8 frame of 8'hAB.
  - Required: 8'hAB frame completes unchanged at 8 cycles/bit; 8'h55 is never sent.
- Back-to-back:
  - Stimulus: data_valid held high with P_DATA=8'h0F then 8'hF0 (prescale=8).
  - Required: two complete frames separated by exactly one TX_OUT=1 idle cycle; two tx_done pulses.
- Reset mid-frame:
  - Stimulus: assert RST during data bit 3 of a prescale=8 frame.
  - Required: next cycle TX_OUT=1, busy=0.
  - Required: a subsequent 8'hAB request produces a clean full frame, and a `UART_RX` instance fed from TX_OUT reports P_DATA=8'hAB with data_valid.
